// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage with a dmem req/gnt/rvalid handshake and registered writeback.
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd,
    input  logic [2:0]      funct3,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            reg_write,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_misalign
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t          state;
    logic [XLEN-1:0] addr_q;
    logic [4:0]      rd_q;
    logic [2:0]      f3_q;
    logic            rw_q;
    logic            accept, mem_op, misalign;
    logic [3:0]      strb;
    logic [XLEN-1:0] wdata, load_data;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    assign ex_ready = state == IDLE;
    assign accept   = ex_valid & ex_ready;
    assign mem_op   = mem_read | mem_write;
    // funct3[1] set means word access, which covers the 011/110/111 encodings too
    assign misalign = mem_op & ((funct3[1:0] == 2'b01 & alu_result[0]) | (funct3[1] & |alu_result[1:0]));

    always_comb begin
        strb      = mem_read ? 4'b0000 : funct3[1] ? 4'b1111 :
                    funct3[0] ? (alu_result[1] ? 4'b1100 : 4'b0011) : 4'b0001 << alu_result[1:0];
        wdata     = funct3[1] ? rs2_data : funct3[0] ? {2{rs2_data[15:0]}} : {4{rs2_data[7:0]}};
        byte_sel  = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel  = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_data = f3_q[1] ? dmem_rdata :
                    f3_q[0] ? {{(XLEN-16){half_sel[15] & ~f3_q[2]}}, half_sel} :
                              {{(XLEN-8){byte_sel[7] & ~f3_q[2]}}, byte_sel};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr_q       <= '0;
            rd_q         <= '0;
            f3_q         <= '0;
            rw_q         <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_wstrb   <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
            wb_misalign  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    addr_q <= alu_result;
                    rd_q   <= rd;
                    f3_q   <= funct3;
                    rw_q   <= reg_write;
                    if (!mem_op || misalign) begin
                        wb_valid     <= 1'b1;
                        wb_rd        <= rd;
                        wb_data      <= alu_result;
                        wb_reg_write <= reg_write & ~misalign;
                        wb_misalign  <= misalign;
                    end else begin
                        state      <= REQ;
                        dmem_req   <= 1'b1;
                        dmem_we    <= ~mem_read;
                        dmem_addr  <= {alu_result[XLEN-1:2], 2'b00};
                        dmem_wdata <= wdata;
                        dmem_wstrb <= strb;
                    end
                end
                REQ: if (dmem_gnt) begin
                    dmem_req <= 1'b0;
                    state    <= dmem_we ? IDLE : WAIT;
                    if (dmem_we) begin
                        wb_valid     <= 1'b1;
                        wb_rd        <= rd_q;
                        wb_data      <= addr_q;
                        wb_reg_write <= 1'b0;
                        wb_misalign  <= 1'b0;
                    end
                end
                WAIT: if (dmem_rvalid) begin
                    state        <= IDLE;
                    wb_valid     <= 1'b1;
                    wb_rd        <= rd_q;
                    wb_data      <= load_data;
                    wb_reg_write <= rw_q;
                    wb_misalign  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] alu_result = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd = '0;
    logic [2:0]  funct3 = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        reg_write = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        wb_misalign;
    int cnt = 0;
    int mism = 0;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_result(alu_result), .rs2_data(rs2_data), .rd(rd), .funct3(funct3),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data), .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                         input logic [2:0] f, input logic mr, input logic mw, input logic rw);
        ex_valid = 1'b1; alu_result = a; rs2_data = d; rd = r; funct3 = f;
        mem_read = mr; mem_write = mw; reg_write = rw;
    endtask

    task automatic idle();
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        cnt++; if (ex_ready !== 1'b1) begin mism++; $display("FAIL reset_ex_ready got=%b exp=1", ex_ready); end
        cnt++; if (dmem_req !== 1'b0) begin mism++; $display("FAIL reset_dmem_req got=%b exp=0", dmem_req); end
        cnt++; if ({dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== 69'd0) begin mism++; $display("FAIL reset_dmem_fields got=%b %h %h %b exp=0", dmem_we, dmem_addr, dmem_wdata, dmem_wstrb); end
        cnt++; if ({wb_valid, wb_rd, wb_reg_write, wb_data, wb_misalign} !== 40'd0) begin mism++; $display("FAIL reset_wb got=%b %h %b %h %b exp=0", wb_valid, wb_rd, wb_reg_write, wb_data, wb_misalign); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_pipeline();
        issue(32'd30, 32'h0, 5'd5, 3'b000, 1'b0, 1'b0, 1'b1);
        cnt++; if (ex_ready !== 1'b1) begin mism++; $display("FAIL alu_ready0 got=%b exp=1", ex_ready); end
        tick();
        cnt++; if ({wb_valid, wb_rd, wb_reg_write, wb_misalign} !== {1'b1, 5'd5, 1'b1, 1'b0}) begin mism++; $display("FAIL add_ctrl got=%b %0d %b %b exp=1 5 1 0", wb_valid, wb_rd, wb_reg_write, wb_misalign); end
        cnt++; if (wb_data !== 32'd30) begin mism++; $display("FAIL add_data got=%h exp=%h", wb_data, 32'd30); end
        cnt++; if (ex_ready !== 1'b1) begin mism++; $display("FAIL alu_ready1 got=%b exp=1", ex_ready); end
        issue(32'hFFFF_FFF6, 32'h0, 5'd6, 3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        cnt++; if ({wb_valid, wb_rd} !== {1'b1, 5'd6}) begin mism++; $display("FAIL sub_ctrl got=%b %0d exp=1 6", wb_valid, wb_rd); end
        cnt++; if (wb_data !== 32'hFFFF_FFF6) begin mism++; $display("FAIL sub_data got=%h exp=fffffff6", wb_data); end
        cnt++; if (ex_ready !== 1'b1) begin mism++; $display("FAIL alu_ready2 got=%b exp=1", ex_ready); end
        cnt++; if (dmem_req !== 1'b0) begin mism++; $display("FAIL alu_no_req got=%b exp=0", dmem_req); end
        tick();
        cnt++; if (wb_valid !== 1'b0) begin mism++; $display("FAIL alu_pulse got=%b exp=0", wb_valid); end
    endtask

    task automatic test_store_sb();
        issue(32'h1003, 32'h0000_00A5, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            cnt++; if ({dmem_req, dmem_we, ex_ready, wb_valid} !== 4'b1100) begin mism++; $display("FAIL sb_req_ctrl[%0d] got=%b%b%b%b exp=1100", i, dmem_req, dmem_we, ex_ready, wb_valid); end
            cnt++; if ({dmem_addr, dmem_wdata, dmem_wstrb} !== {32'h1000, 32'hA5A5_A5A5, 4'b1000}) begin mism++; $display("FAIL sb_fields[%0d] got=%h %h %b exp=1000 a5a5a5a5 1000", i, dmem_addr, dmem_wdata, dmem_wstrb); end
            dmem_gnt = (i == 2);
            tick();
        end
        dmem_gnt = 1'b0;
        cnt++; if ({dmem_req, ex_ready, wb_valid, wb_reg_write, wb_misalign} !== 5'b01100) begin mism++; $display("FAIL sb_retire got=%b%b%b%b%b exp=01100", dmem_req, ex_ready, wb_valid, wb_reg_write, wb_misalign); end
        cnt++; if (wb_data !== 32'h1003) begin mism++; $display("FAIL sb_wb_data got=%h exp=00001003", wb_data); end
        issue(32'h1006, 32'h0000_BEEF, 5'd0, 3'b001, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        cnt++; if ({dmem_addr, dmem_wdata, dmem_wstrb} !== {32'h1004, 32'hBEEF_BEEF, 4'b1100}) begin mism++; $display("FAIL sh_fields got=%h %h %b exp=1004 beefbeef 1100", dmem_addr, dmem_wdata, dmem_wstrb); end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        cnt++; if ({wb_valid, ex_ready, dmem_req} !== 3'b110) begin mism++; $display("FAIL sh_retire got=%b%b%b exp=110", wb_valid, ex_ready, dmem_req); end
        tick();
    endtask

    task automatic test_load(input string name, input logic [31:0] a, input logic [2:0] f,
                             input logic [31:0] rdata, input logic [31:0] exp);
        issue(a, 32'h0, 5'd7, f, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        cnt++; if ({dmem_req, dmem_we, dmem_wstrb, ex_ready} !== 7'b1000000) begin mism++; $display("FAIL %s_req got=%b %b %b %b exp=1 0 0000 0", name, dmem_req, dmem_we, dmem_wstrb, ex_ready); end
        cnt++; if (dmem_addr !== {a[31:2], 2'b00}) begin mism++; $display("FAIL %s_addr got=%h exp=%h", name, dmem_addr, {a[31:2], 2'b00}); end
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = ~rdata;
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        cnt++; if ({dmem_req, ex_ready, wb_valid} !== 3'b000) begin mism++; $display("FAIL %s_wait got=%b%b%b exp=000", name, dmem_req, ex_ready, wb_valid); end
        issue(32'hDEAD, 32'h0, 5'd1, 3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        cnt++; if ({ex_ready, wb_valid} !== 2'b00) begin mism++; $display("FAIL %s_busy got=%b%b exp=00", name, ex_ready, wb_valid); end
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        cnt++; if ({wb_valid, wb_rd, wb_reg_write, wb_misalign, ex_ready} !== {1'b1, 5'd7, 1'b1, 1'b0, 1'b1}) begin mism++; $display("FAIL %s_ctrl got=%b %0d %b %b %b exp=1 7 1 0 1", name, wb_valid, wb_rd, wb_reg_write, wb_misalign, ex_ready); end
        cnt++; if (wb_data !== exp) begin mism++; $display("FAIL %s_data got=%h exp=%h", name, wb_data, exp); end
        tick();
        cnt++; if (wb_valid !== 1'b0) begin mism++; $display("FAIL %s_pulse got=%b exp=0", name, wb_valid); end
    endtask

    task automatic test_misalign();
        issue(32'h4001, 32'h0, 5'd8, 3'b010, 1'b1, 1'b0, 1'b1);
        tick();
        cnt++; if ({dmem_req, wb_valid, wb_misalign, wb_reg_write, ex_ready} !== 5'b01101) begin mism++; $display("FAIL mis_lw_ctrl got=%b%b%b%b%b exp=01101", dmem_req, wb_valid, wb_misalign, wb_reg_write, ex_ready); end
        cnt++; if (wb_data !== 32'h4001) begin mism++; $display("FAIL mis_lw_data got=%h exp=00004001", wb_data); end
        issue(32'h4003, 32'h1234, 5'd0, 3'b001, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        cnt++; if ({dmem_req, wb_valid, wb_misalign, wb_reg_write, ex_ready} !== 5'b01101) begin mism++; $display("FAIL mis_sh_ctrl got=%b%b%b%b%b exp=01101", dmem_req, wb_valid, wb_misalign, wb_reg_write, ex_ready); end
        cnt++; if (wb_data !== 32'h4003) begin mism++; $display("FAIL mis_sh_data got=%h exp=00004003", wb_data); end
        tick();
        cnt++; if ({dmem_req, wb_valid} !== 2'b00) begin mism++; $display("FAIL mis_after got=%b%b exp=00", dmem_req, wb_valid); end
    endtask

    task automatic test_reset_mid();
        issue(32'h5000, 32'h0, 5'd9, 3'b010, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        cnt++; if ({dmem_req, ex_ready, wb_valid, dmem_addr} !== {3'b010, 32'h0}) begin mism++; $display("FAIL rst_async got=%b%b%b %h exp=010 00000000", dmem_req, ex_ready, wb_valid, dmem_addr); end
        tick();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_rvalid = 1'b0;
        cnt++; if ({wb_valid, ex_ready, dmem_req, wb_data} !== {3'b010, 32'h0}) begin mism++; $display("FAIL rst_stray_rvalid got=%b%b%b %h exp=010 00000000", wb_valid, ex_ready, dmem_req, wb_data); end
        issue(32'd42, 32'h0, 5'd3, 3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        cnt++; if ({wb_valid, wb_rd, wb_reg_write, wb_data} !== {1'b1, 5'd3, 1'b1, 32'd42}) begin mism++; $display("FAIL rst_add got=%b %0d %b %h exp=1 3 1 0000002a", wb_valid, wb_rd, wb_reg_write, wb_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_pipeline();
        test_store_sb();
        test_load("lb",  32'h2002, 3'b000, 32'h12F0_3456, 32'hFFFF_FFF0);
        test_load("lbu", 32'h2002, 3'b100, 32'h12F0_3456, 32'h0000_00F0);
        test_load("lb0", 32'h2000, 3'b000, 32'h12F0_3456, 32'h0000_0056);
        test_load("lh",  32'h3002, 3'b001, 32'h8001_0000, 32'hFFFF_8001);
        test_load("lhu", 32'h3002, 3'b101, 32'h8001_0000, 32'h0000_8001);
        test_load("lw",  32'h3000, 3'b010, 32'h8001_0000, 32'h8001_0000);
        test_misalign();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, mism);
        $finish;
    end
endmodule
